rvfi_retire_queue: RTL and testbench

RVFI_RETIRE_QUEUE -- requirements
Module: rvfi_retire_queue

---
 rtl/rvfi_retire_queue.sv | 104 ++++++++++
 tb/tb_rvfi_retire_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_retire_queue.sv
// rvfi_retire_queue: buffers retired-instruction RVFI packets between the core
// and a formal/trace monitor, tags each packet with a 64-bit retirement order
// and flags overflow drops and PC discontinuities in a sticky error word.
module rvfi_retire_queue #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 247
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_pc_rdata,
    input  logic [31:0]             in_pc_wdata,
    input  logic [PAYLOAD_W-1:0]    in_payload,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc_rdata,
    output logic [31:0]             out_pc_wdata,
    output logic [PAYLOAD_W-1:0]    out_payload,
    output logic [63:0]             out_order,
    output logic [15:0]             errcode,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]          pc_rdata_mem [DEPTH];
    logic [31:0]          pc_wdata_mem [DEPTH];
    logic [PAYLOAD_W-1:0] payload_mem  [DEPTH];
    logic [63:0]          order_mem    [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [63:0]   order;
    logic [31:0]   prev_wdata;
    logic          seen_push;
    logic          ovf_err;
    logic          disc_err;
    logic [7:0]    drop_cnt;

    logic push;
    logic pop;
    logic drop;

    // Handshakes come from registered occupancy only; out_ready never reaches in_ready.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign drop      = in_valid && !in_ready;

    assign out_pc_rdata = pc_rdata_mem[head];
    assign out_pc_wdata = pc_wdata_mem[head];
    assign out_payload  = payload_mem[head];
    assign out_order    = order_mem[head];
    assign errcode      = {drop_cnt, 6'b0, disc_err, ovf_err};

    // Packet storage: contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_rdata_mem[tail] <= in_pc_rdata;
            pc_wdata_mem[tail] <= in_pc_wdata;
            payload_mem[tail]  <= in_payload;
            order_mem[tail]    <= order;
        end
    end

    // Pointers, occupancy, order counter, continuity tracking and error status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            order      <= '0;
            prev_wdata <= '0;
            seen_push  <= 1'b0;
            ovf_err    <= 1'b0;
            disc_err   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (push) begin
                tail       <= tail + AW'(1);
                order      <= order + 64'd1;
                prev_wdata <= in_pc_wdata;
                seen_push  <= 1'b1;
                // The first packet after reset has no predecessor to compare with.
                if (seen_push && (in_pc_rdata != prev_wdata))
                    disc_err <= 1'b1;
            end
            if (pop)
                head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                ovf_err <= 1'b1;
                if (drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_rvfi_retire_queue.sv
// Bench for rvfi_retire_queue: directed stimulus pushes expected packets into a
// scoreboard; an independent monitor compares every popped head against it.
module tb_rvfi_retire_queue;
    localparam int DEPTH = 4;
    localparam int PW    = 247;

    typedef struct {
        logic [31:0] pcr;
        logic [31:0] pcw;
        logic [PW-1:0] pay;
        logic [63:0] ord;
    } pkt_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc_rdata;
    logic [31:0]   in_pc_wdata;
    logic [PW-1:0] in_payload;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc_rdata;
    logic [31:0]   out_pc_wdata;
    logic [PW-1:0] out_payload;
    logic [63:0]   out_order;
    logic [15:0]   errcode;
    logic [2:0]    count;

    pkt_t        sb[$];
    logic [63:0] exp_order;
    int          n_cmp = 0;
    int          n_bad = 0;

    rvfi_retire_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata), .out_payload(out_payload),
        .out_order(out_order), .errcode(errcode), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mkpay(input logic [31:0] a, input logic [31:0] b);
        logic [255:0] w;
        w = {a ^ 32'hA5A5_5A5A, b, a, b, 32'hDEAD_BEEF, a + b, ~a, b};
        return w[PW-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one packet for one cycle; exp_acc is the hand-derived accept decision.
    task automatic push(input logic [31:0] pcr, input logic [31:0] pcw, input logic exp_acc);
        pkt_t p;
        in_valid    = 1'b1;
        in_pc_rdata = pcr;
        in_pc_wdata = pcw;
        in_payload  = mkpay(pcr, pcw);
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(exp_acc));
        if (exp_acc) begin
            p.pcr = pcr; p.pcw = pcw; p.pay = mkpay(pcr, pcw); p.ord = exp_order;
            sb.push_back(p);
            exp_order++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Asynchronous reset away from any edge; checks reset values before releasing.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_errcode", 64'(errcode), 64'd0);
        sb.delete();
        exp_order = '0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drain(input int budget);
        int n;
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (count != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 64'(count), 64'd0);
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: a pop commits at the next rising edge, so compare the head now.
    initial begin
        pkt_t e;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pop", 64'(out_order), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("out_pc_rdata", 64'(out_pc_rdata), 64'(e.pcr));
                    chk("out_pc_wdata", 64'(out_pc_wdata), 64'(e.pcw));
                    chk("out_order", out_order, e.ord);
                    chk("out_payload", 64'(out_payload == e.pay), 64'd1);
                end
            end
        end
    end

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_pc_rdata = '0;
        in_pc_wdata = '0;
        in_payload  = '0;
        exp_order   = '0;
        #1;
        chk("init_out_valid", 64'(out_valid), 64'd0);
        chk("init_in_ready", 64'(in_ready), 64'd1);
        chk("init_errcode", 64'(errcode), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Single packet through an empty queue, monitor always ready.
        out_ready = 1'b1;
        push(32'h100, 32'h104, 1'b1);
        chk("single_out_valid", 64'(out_valid), 64'd1);
        chk("single_count", 64'(count), 64'd1);
        @(posedge clk); #1;
        chk("single_count_after", 64'(count), 64'd0);
        // Idle out_ready with empty queue changes nothing.
        repeat (2) @(posedge clk);
        #1;
        chk("idle_count", 64'(count), 64'd0);
        chk("single_errcode", 64'(errcode), 64'd0);

        // PC discontinuity is flagged but both packets delivered.
        do_reset();
        out_ready = 1'b0;
        push(32'h100, 32'h104, 1'b1);
        push(32'h108, 32'h10C, 1'b1);
        chk("cont_errcode", 64'(errcode), 64'h0002);
        drain(10);

        // Fill with monitor stalled: fifth packet dropped.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push(32'h200 + 32'(4*i), 32'h204 + 32'(4*i), i < 4);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_errcode", 64'(errcode), 64'h0101);
        drain(10);

        // Drop counter saturates; order continues from 4 afterwards.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push(32'h200 + 32'(4*i), 32'h204 + 32'(4*i), 1'b1);
        for (int i = 0; i < 300; i++)
            push(32'h900 + 32'(4*i), 32'h904 + 32'(4*i), 1'b0);
        chk("sat_errcode", 64'(errcode), 64'hFF01);
        drain(10);
        out_ready = 1'b1;
        push(32'h210, 32'h214, 1'b1);
        drain(10);
        chk("sat_errcode_after", 64'(errcode), 64'hFF01);

        // Streaming with both sides always ready.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push(32'h400 + 32'(4*i), 32'h404 + 32'(4*i), 1'b1);
            chk("stream_count_le1", 64'(count <= 3'd1), 64'd1);
        end
        drain(10);
        chk("stream_errcode", 64'(errcode), 64'd0);

        // Reset mid-stream discards queued packets and restarts order at 0.
        do_reset();
        out_ready = 1'b0;
        push(32'h100, 32'h104, 1'b1);
        push(32'h300, 32'h304, 1'b1);
        push(32'h304, 32'h308, 1'b1);
        chk("mid_count", 64'(count), 64'd3);
        chk("mid_errcode", 64'(errcode), 64'h0002);
        do_reset();
        out_ready = 1'b1;
        push(32'h500, 32'h504, 1'b1);
        drain(10);
        chk("post_rst_errcode", 64'(errcode), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
